keypad_cmd_ctrl: RTL
====================

# keypad_cmd_ctrl

Sequences the 4x4 keypad scanner's raw key output into maze-game commands. It qualifies each press for stability and maps key codes to movement and control commands. Held direction keys auto-repeat. Commands go into a small FIFO that the game logic drains over a valid/ready handshake. The block sits between the keypad scanner and the maze state machine, all in the 50 MHz `clk` domain.

## Interface
- `STABLE_CYC`, default 1000: consecutive matching cycles required to accept a press or release (must be ≥1).
- `REPEAT_DLY`, default 25000000: cycles from first command to first auto-repeat (must be ≥1).
- `REPEAT_INT`, default 5000000: cycles between subsequent auto-repeats (must be ≥1).
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two, ≥2.
- `clk`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  reset, synchronous, active-high.
- `key_valid`  in  1  scanner reports a key held.
- `key_code`  in  4  scanner key value 0–15; meaningful only while `key_valid`=1.
- `cmd_ready`  in  1  consumer accepts the head command this cycle.
- `cmd_valid`  out  1  FIFO not empty.
- `cmd`  out  3  head command: 1=UP, 2=LEFT, 3=RIGHT, 4=DOWN, 5=RESTART, 6=PAUSE.
- `fifo_cnt`  out  clog2(FIFO_DEPTH)+1  number of FIFO entries.
- `overflow`  out  1  sticky flag; set when a command is dropped because the FIFO is full.
- `state`  out  3  FSM state for debug: 0=IDLE, 1=QUAL, 2=HELD_FIRST, 3=HELD_REPEAT, 4=RELEASE.

## Operation
- **Key map:** 1→UP, 4→LEFT, 6→RIGHT, 9→DOWN, 0→RESTART, 15→PAUSE. All other codes are unmapped: they pass through the FSM normally but produce no push. Only UP, LEFT, RIGHT and DOWN auto-repeat.
- **Cycle counter:** one shared counter, wide enough for max(STABLE_CYC, REPEAT_DLY, REPEAT_INT). It is cleared on every state entry.
- **IDLE:**
  - `key_valid`=1 → latch `key_code` into `cur_code` and go to QUAL.
- **QUAL:**
  - `key_valid`=0 → IDLE.
  - `key_code`≠`cur_code` → latch the new code and stay in QUAL with the counter cleared.
  - Match and counter = STABLE_CYC-1 → push the mapped command, then go to HELD_FIRST.
  - Match otherwise → increment the counter.
- **HELD_FIRST:**
  - `key_valid`=0 → RELEASE.
  - Code change → latch the new code and go to QUAL.
  - Counter = REPEAT_DLY-1 and `cur_code` is a direction → push, then go to HELD_REPEAT.
  - Non-direction key → counter saturates at REPEAT_DLY-1; stay in HELD_FIRST.
- **HELD_REPEAT:**
  - Release and code-change rules are the same as HELD_FIRST.
  - Counter = REPEAT_INT-1 → push and clear the counter.
- **RELEASE:**
  - `key_valid`=1 → clear the counter and stay in RELEASE. Bounce produces no command.
  - Counter = STABLE_CYC-1 with `key_valid`=0 → IDLE.
- **FIFO:** registered memory with read/write pointers that wrap modulo FIFO_DEPTH. `cmd` is the entry at the read pointer.
  - Pop when `cmd_valid` && `cmd_ready`.
  - Push is accepted if `fifo_cnt` < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets `overflow`. Only `reset` clears `overflow`.
  - `fifo_cnt` changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.

## Timing
- **Reset:** applied on the `clk` edge where `reset`=1. It overrides all other activity, including a mid-press state or a pending push.
  - Afterwards: `state`=IDLE, counter=0, `cur_code`=0, pointers=0, `fifo_cnt`=0, `cmd_valid`=0, `cmd`=0, `overflow`=0.
- **First-command latency:** let edge 0 be the first edge that samples `key_valid`=1 in IDLE. The push occurs at edge STABLE_CYC, and `cmd_valid` is high immediately after that edge.
- **Repeat timing:** the first repeat push comes REPEAT_DLY edges after the initial push. Each later repeat comes REPEAT_INT edges after the previous one.
- **Handshake:**
  - `cmd`/`cmd_valid` change only after a pop or after a push into an empty FIFO.
  - A push into an empty FIFO is visible the next cycle. There is no bypass.
- **Pop on empty:** `cmd_ready` with `cmd_valid`=0 has no effect.
- **Same-cycle push and pop:** a push arriving while the FIFO is full and a pop occurs is accepted; `fifo_cnt` stays at FIFO_DEPTH.

## Test plan
Bench parameters: STABLE_CYC=4, REPEAT_DLY=20, REPEAT_INT=8, FIFO_DEPTH=4.

- **Single press:** hold key 6 for 10 cycles with `cmd_ready`=1 → exactly one `cmd`=3 beat, with `cmd_valid` high after edge 4. Then, after release + 4 quiet cycles → `state`=0.
- **Bounce:** toggle `key_valid` with a period of 3 cycles while showing key 1 → no push; `state` alternates 0/1.
- **Auto-repeat:** hold key 9 for 45 cycles with `cmd_ready`=1 → `cmd`=4 at pushes on edges 4, 24, 32 and 40 (four beats). Holding key 0 for 45 cycles → only one `cmd`=5.
- **Overflow:** with `cmd_ready`=0, hold key 4 for 60 cycles → `fifo_cnt`=4, `overflow`=1 after the fifth push. Then assert `cmd_ready` → four `cmd`=2 beats, then `cmd_valid`=0.
- **Key change while held:** hold 1, switch to 6 at cycle 12 without releasing → `cmd`=1, then `cmd`=3 four edges after the switch.
- **Reset mid-operation:** assert `reset` for 1 cycle while in HELD_REPEAT with 2 entries queued → next cycle `state`=0, `fifo_cnt`=0, `cmd_valid`=0, `overflow`=0.

Source files
------------

// File: rtl/keypad_cmd_ctrl.sv
// rtl/keypad_cmd_ctrl.sv - keypad press qualifier, command mapper with auto-repeat, and command FIFO
// Scanner key codes are debounced, mapped to maze commands and queued for the game logic.

module keypad_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [2:0]       i_push_data,
   input  logic             i_pop_req,
   output logic             o_valid,
   output logic [2:0]       o_data,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_overflow
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [2:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_overflow;

   logic w_full;
   logic w_pop;
   logic w_push_ok;

   assign w_full    = (r_cnt == CNT_W'(DEPTH));
   assign w_pop     = (r_cnt != '0) && i_pop_req;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok = i_push && (!w_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push_ok && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push_ok && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (i_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_valid    = (r_cnt != '0);
   assign o_data     = r_mem[r_rd_ptr];
   assign o_cnt      = r_cnt;
   assign o_overflow = r_overflow;
endmodule

module keypad_cmd_ctrl #(
   parameter int STABLE_CYC = 1000,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_INT = 5000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_key_valid,
   input  logic [3:0]                  i_key_code,
   input  logic                        i_cmd_ready,
   output logic                        o_cmd_valid,
   output logic [2:0]                  o_cmd,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
   output logic                        o_overflow,
   output logic [2:0]                  o_state
);
   localparam int MAX_SD  = (STABLE_CYC > REPEAT_DLY) ? STABLE_CYC : REPEAT_DLY;
   localparam int CYC_MAX = (MAX_SD > REPEAT_INT) ? MAX_SD : REPEAT_INT;
   // The counter only ever reaches CYC_MAX-1.
   localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYC - 1);
   localparam logic [CYC_W-1:0] DLY_LAST    = CYC_W'(REPEAT_DLY - 1);
   localparam logic [CYC_W-1:0] INT_LAST    = CYC_W'(REPEAT_INT - 1);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_QUAL        = 3'd1;
   localparam logic [2:0] S_HELD_FIRST  = 3'd2;
   localparam logic [2:0] S_HELD_REPEAT = 3'd3;
   localparam logic [2:0] S_RELEASE     = 3'd4;

   localparam logic [2:0] CMD_NONE    = 3'd0;
   localparam logic [2:0] CMD_UP      = 3'd1;
   localparam logic [2:0] CMD_LEFT    = 3'd2;
   localparam logic [2:0] CMD_RIGHT   = 3'd3;
   localparam logic [2:0] CMD_DOWN    = 3'd4;
   localparam logic [2:0] CMD_RESTART = 3'd5;
   localparam logic [2:0] CMD_PAUSE   = 3'd6;

   logic [2:0]       r_state;
   logic [CYC_W-1:0] r_cyc;
   logic [3:0]       r_cur_code;

   logic [2:0] w_map_cmd;
   logic       w_is_dir;
   logic       w_code_match;
   logic       w_push;

   always_comb begin
      w_map_cmd = CMD_NONE;
      case (r_cur_code)
         4'd1:    w_map_cmd = CMD_UP;
         4'd4:    w_map_cmd = CMD_LEFT;
         4'd6:    w_map_cmd = CMD_RIGHT;
         4'd9:    w_map_cmd = CMD_DOWN;
         4'd0:    w_map_cmd = CMD_RESTART;
         4'd15:   w_map_cmd = CMD_PAUSE;
         default: w_map_cmd = CMD_NONE;
      endcase
   end

   assign w_is_dir     = (w_map_cmd >= CMD_UP) && (w_map_cmd <= CMD_DOWN);
   assign w_code_match = (i_key_code == r_cur_code);

   always_comb begin
      w_push = 1'b0;
      if (i_key_valid && w_code_match) begin
         case (r_state)
            S_QUAL:        w_push = (r_cyc == STABLE_LAST) && (w_map_cmd != CMD_NONE);
            S_HELD_FIRST:  w_push = (r_cyc == DLY_LAST) && w_is_dir;
            S_HELD_REPEAT: w_push = (r_cyc == INT_LAST) && w_is_dir;
            default:       w_push = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cyc      <= '0;
         r_cur_code <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_key_valid) begin
                  r_cur_code <= i_key_code;
                  r_state    <= S_QUAL;
                  r_cyc      <= '0;
               end
            end
            S_QUAL: begin
               if (!i_key_valid) begin
                  r_state <= S_IDLE;
                  r_cyc   <= '0;
               end else if (!w_code_match) begin
                  r_cur_code <= i_key_code;
                  r_cyc      <= '0;
               end else if (r_cyc == STABLE_LAST) begin
                  r_state <= S_HELD_FIRST;
                  r_cyc   <= '0;
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end
            S_HELD_FIRST: begin
               if (!i_key_valid) begin
                  r_state <= S_RELEASE;
                  r_cyc   <= '0;
               end else if (!w_code_match) begin
                  r_cur_code <= i_key_code;
                  r_state    <= S_QUAL;
                  r_cyc      <= '0;
               end else if (r_cyc == DLY_LAST) begin
                  // Non-direction keys park here with the counter saturated.
                  if (w_is_dir) begin
                     r_state <= S_HELD_REPEAT;
                     r_cyc   <= '0;
                  end
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end
            S_HELD_REPEAT: begin
               if (!i_key_valid) begin
                  r_state <= S_RELEASE;
                  r_cyc   <= '0;
               end else if (!w_code_match) begin
                  r_cur_code <= i_key_code;
                  r_state    <= S_QUAL;
                  r_cyc      <= '0;
               end else if (r_cyc == INT_LAST) begin
                  r_cyc <= '0;
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end
            S_RELEASE: begin
               if (i_key_valid) begin
                  r_cyc <= '0;
               end else if (r_cyc == STABLE_LAST) begin
                  r_state <= S_IDLE;
                  r_cyc   <= '0;
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cyc   <= '0;
            end
         endcase
      end
   end

   keypad_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_push),
      .i_push_data (w_map_cmd),
      .i_pop_req   (i_cmd_ready),
      .o_valid     (o_cmd_valid),
      .o_data      (o_cmd),
      .o_cnt       (o_fifo_cnt),
      .o_overflow  (o_overflow)
   );

   assign o_state = r_state;
endmodule
